alu_arbiter: RTL and testbench

Shares the single combinational ALU datapath (signed 32-bit inputA/inputB, 4-bit ALUop, ALUResult/negative/zero) between two requesters: requester 0 (execute stage) and requester 1 (branch-compare/address-generation unit). Requests are accepted with valid/ready handshakes and operands are registered before they drive the ALU. The result, flags and requester ID are returned on a single registered response channel with valid/ready backpressure. The block sits between the issue logic and the ALU; nothing else drives the ALU inputs.

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response bundle shared by alu_arbiter and its environment
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
);
   logic                    req0_valid;
   logic                    req0_ready;
   logic signed [WIDTH-1:0] req0_a;
   logic signed [WIDTH-1:0] req0_b;
   logic [OPW-1:0]          req0_op;

   logic                    req1_valid;
   logic                    req1_ready;
   logic signed [WIDTH-1:0] req1_a;
   logic signed [WIDTH-1:0] req1_b;
   logic [OPW-1:0]          req1_op;

   logic signed [WIDTH-1:0] alu_inputA;
   logic signed [WIDTH-1:0] alu_inputB;
   logic [OPW-1:0]          alu_op;
   logic signed [WIDTH-1:0] alu_result;
   logic                    alu_negative;
   logic                    alu_zero;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic                    rsp_id;
   logic signed [WIDTH-1:0] rsp_result;
   logic                    rsp_negative;
   logic                    rsp_zero;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output alu_inputA, alu_inputB, alu_op,
      input  alu_result, alu_negative, alu_zero,
      output rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  alu_inputA, alu_inputB, alu_op,
      output alu_result, alu_negative, alu_zero,
      input  rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter for a shared combinational ALU with registered response
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0 first) otherwise.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input logic         clk,
   input logic         rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [OPW-1:0]   op_code;
   logic             issue_id;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_negative_q;
   logic             rsp_zero_q;

   logic             idle;
   logic             grant0;
   logic             grant1;

`ifdef ALU_ARB_RR_EN
   logic             last_grant;
`endif

   // Readies are suppressed while rst is high so no handshake can be lost to reset.
   always_comb begin
      idle = (state == IDLE) && !rst;
`ifdef ALU_ARB_RR_EN
      grant0 = idle && bus.req0_valid && (!bus.req1_valid || last_grant);
      grant1 = idle && bus.req1_valid && (!bus.req0_valid || !last_grant);
`else
      grant0 = idle && bus.req0_valid;
      grant1 = idle && bus.req1_valid && !bus.req0_valid;
`endif
   end

   assign bus.req0_ready   = grant0;
   assign bus.req1_ready   = grant1;
   assign bus.alu_inputA   = op_a;
   assign bus.alu_inputB   = op_b;
   assign bus.alu_op       = op_code;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_negative = rsp_negative_q;
   assign bus.rsp_zero     = rsp_zero_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         op_a           <= '0;
         op_b           <= '0;
         op_code        <= '0;
         issue_id       <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= 1'b0;
         rsp_result_q   <= '0;
         rsp_negative_q <= 1'b0;
         rsp_zero_q     <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_grant     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_a     <= grant1 ? bus.req1_a  : bus.req0_a;
                  op_b     <= grant1 ? bus.req1_b  : bus.req0_b;
                  op_code  <= grant1 ? bus.req1_op : bus.req0_op;
                  issue_id <= grant1;
`ifdef ALU_ARB_RR_EN
                  last_grant <= grant1;
`endif
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_result_q   <= bus.alu_result;
               rsp_negative_q <= bus.alu_negative;
               rsp_zero_q     <= bus.alu_zero;
               rsp_id_q       <= issue_id;
               rsp_valid_q    <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter with a stub ALU and reference model
module tb_alu_arbiter;
   localparam int WIDTH = 32;
   localparam int OPW   = 4;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   model_last = 1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();
   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA.
   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (op)
         4'd0: return 32'(sa + sb);
         4'd1: return 32'(sa - sb);
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (sa < sb) ? 32'd1 : 32'd0;
         4'd6: return a << b[4:0];
         4'd7: return a >> b[4:0];
         4'd8: return 32'(sa >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   assign bus.alu_result   = alu_ref(bus.alu_op, bus.alu_inputA, bus.alu_inputB);
   assign bus.alu_negative = bus.alu_result[WIDTH-1];
   assign bus.alu_zero     = (bus.alu_result == '0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int ready_of(input int id);
      return (id == 0) ? 32'(bus.req0_ready) : 32'(bus.req1_ready);
   endfunction

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      if (id == 0) begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end
   endtask

   task automatic drop_req(input int id);
      if (id == 0) bus.req0_valid = 1'b0;
      else bus.req1_valid = 1'b0;
   endtask

   task automatic check_rsp(input string tag, input int id, input logic [31:0] exp);
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
      check({tag, "_result"}, bus.rsp_result, exp);
      check({tag, "_negative"}, 32'(bus.rsp_negative), 32'(exp[31]));
      check({tag, "_zero"}, 32'(bus.rsp_zero), (exp == 32'd0) ? 32'd1 : 32'd0);
   endtask

   // Entered and left just after a rising edge; expects rsp_ready high.
   task automatic run_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          output int acc_cyc);
      logic [31:0] exp;
      int n;
      exp = alu_ref(op, a, b);
      set_req(id, a, b, op);
      n = 0;
      @(negedge clk);
      while (ready_of(id) == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready", 32'(ready_of(id)), 32'd1);
      check("other_ready", 32'(ready_of(1 - id)), 32'd0);
      @(posedge clk); #1;
      acc_cyc = cyc;
      model_last = id;
      drop_req(id);
      @(negedge clk);
      check("issue_inputA", bus.alu_inputA, a);
      check("issue_inputB", bus.alu_inputB, b);
      check("issue_op", 32'(bus.alu_op), 32'(op));
      check("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check_rsp("rsp", id, exp);
      @(posedge clk); #1;
   endtask

   task automatic run_tie();
      int grants[$];
      int pend[$];
      int n;
      int exp_g;
      int g;
      n = 0;
      set_req(0, 32'd10, 32'd1, OP_ADD);
      set_req(1, 32'd10, 32'd1, OP_SUB);
      while ((grants.size() < 4 || pend.size() > 0) && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.rsp_valid) begin
            if (pend.size() > 0) begin
               g = pend.pop_front();
               check_rsp("tie_rsp", g, (g == 0) ? 32'd11 : 32'd9);
            end else begin
               check("tie_unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end
         end
         if (bus.req0_ready || bus.req1_ready) begin
            if (bus.req0_valid && bus.req1_valid) exp_g = RR ? (1 - model_last) : 0;
            else exp_g = bus.req1_valid ? 1 : 0;
            check("tie_grant", 32'(bus.req1_ready), 32'(exp_g));
            check("tie_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            g = 32'(bus.req1_ready);
            grants.push_back(g);
            pend.push_back(g);
            model_last = g;
         end
         @(posedge clk); #1;
         if (grants.size() >= 4) begin
            drop_req(0);
            drop_req(1);
         end
      end
      check("tie_grant_count", 32'(grants.size()), 32'd4);
      check("tie_drained", 32'(pend.size()), 32'd0);
   endtask

   task automatic run_stall();
      set_req(0, 32'd7, 32'd8, OP_ADD);
      @(negedge clk);
      check("stall_accept", 32'(bus.req0_ready), 32'd1);
      @(posedge clk); #1;
      model_last = 0;
      bus.rsp_ready = 1'b0;
      set_req(0, 32'h0000_00F0, 32'h0000_000F, OP_XOR);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check_rsp("stall_hold", 0, 32'd15);
         check("stall_ready0", 32'(bus.req0_ready), 32'd0);
         check("stall_ready1", 32'(bus.req1_ready), 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_released", 32'(bus.rsp_valid), 32'd0);
      check("stall_next_accept", 32'(bus.req0_ready), 32'd1);
      @(posedge clk); #1;
      model_last = 0;
      drop_req(0);
      @(negedge clk);
      @(negedge clk);
      check_rsp("stall_next", 0, 32'h0000_00FF);
      @(posedge clk); #1;
   endtask

   task automatic run_reset_in_issue();
      set_req(0, 32'd9, 32'd9, OP_ADD);
      @(negedge clk);
      check("rst_pre_accept", 32'(bus.req0_ready), 32'd1);
      @(posedge clk); #1;
      model_last = 0;
      drop_req(0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_last = 1;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("rst_rsp_result", bus.rsp_result, 32'd0);
      check("rst_rsp_negative", 32'(bus.rsp_negative), 32'd0);
      check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
      check("rst_inputA", bus.alu_inputA, 32'd0);
      check("rst_inputB", bus.alu_inputB, 32'd0);
      check("rst_op", 32'(bus.alu_op), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      set_req(0, 32'd1, 32'd2, OP_ADD);
      set_req(1, 32'd3, 32'd4, OP_ADD);
      @(negedge clk);
      check("rst_tie_ready0", 32'(bus.req0_ready), 32'd1);
      check("rst_tie_ready1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      model_last = 0;
      drop_req(0);
      @(negedge clk);
      @(negedge clk);
      check_rsp("rst_tie_first", 0, 32'd3);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_tie_second_ready1", 32'(bus.req1_ready), 32'd1);
      @(posedge clk); #1;
      model_last = 1;
      drop_req(1);
      @(negedge clk);
      @(negedge clk);
      check_rsp("rst_tie_second", 1, 32'd7);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int acc;
      int prev;
      int id;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  rop;
      rst = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("reset_rsp_result", bus.rsp_result, 32'd0);
      check("reset_flags", {30'd0, bus.rsp_negative, bus.rsp_zero}, 32'd0);
      check("reset_alu_inputs", bus.alu_inputA | bus.alu_inputB, 32'd0);
      check("reset_alu_op", 32'(bus.alu_op), 32'd0);
      check("reset_readies_idle", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      @(posedge clk); #1;

      run_req(0, 32'sd5, -32'sd3, OP_ADD, acc);
      run_req(1, 32'sd3, 32'sd3, OP_SUB, acc);
      run_req(1, 32'sd1, 32'sd4, OP_SUB, acc);
      run_tie();
      run_req(1, 32'sd10, 32'sd1, OP_SUB, acc);
      run_stall();
      run_reset_in_issue();

      id = 0;
      prev = 0;
      for (int i = 0; i < 24; i++) begin
         if (i >= 12) id = int'($urandom_range(0, 1));
         ra = $urandom();
         rb = (i % 3 == 0) ? ra : $urandom();
         rop = 4'($urandom_range(0, 8));
         run_req(id, ra, rb, rop, acc);
         if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd3);
         prev = acc;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
